vs_imm_model_scheduler: RTL and testbench



---
 rtl/vs_imm_model_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_vs_imm_model_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vs_imm_model_scheduler.sv
// VS-IMM model scheduler: keeps a hysteresis-filtered model_active mask for the
// IMM mixing stage and the dynamic TPM unit. Each accepted probability beat goes
// through IDLE -> EVAL -> COMMIT. A model is deactivated only after a run of
// low-probability updates, and is probed back after a fixed time inactive.
// The mask never drops below MIN_ACTIVE models.
module vs_imm_model_scheduler #(
    parameter int N_MODELS     = 3,
    parameter int MIN_ACTIVE   = 2,
    parameter int DEACT_CYCLES = 8,
    parameter int REACT_CYCLES = 32,
    parameter int CNT_W        = 8,
    parameter int FP_W         = 32,
    localparam int IDX_W       = (N_MODELS > 1) ? $clog2(N_MODELS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [FP_W-1:0] mu [N_MODELS],
    input  logic                   mu_valid,
    output logic                   mu_ready,
    input  logic                   maneuver_detected,
    input  logic                   vs_imm_enable,
    input  logic signed [FP_W-1:0] mu_deact_thr,
    output logic [N_MODELS-1:0]    model_active,
    output logic [IDX_W-1:0]       dominant_model,
    output logic                   active_valid,
    output logic                   mask_changed
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]    DEACT_MAX = CNT_W'(DEACT_CYCLES);
    localparam logic [CNT_W-1:0]    REACT_MAX = CNT_W'(REACT_CYCLES);
    localparam logic [N_MODELS-1:0] ALL_ON    = {N_MODELS{1'b1}};

    state_t state;
    state_t state_nxt;

    logic                   accept;
    logic signed [FP_W-1:0] mu_q [N_MODELS];
    logic signed [FP_W-1:0] thr_q;
    logic                   maneuver_q;
    logic                   enable_q;

    logic [CNT_W-1:0] deact_cnt  [N_MODELS];
    logic [CNT_W-1:0] react_cnt  [N_MODELS];
    logic [CNT_W-1:0] deact_eval [N_MODELS];
    logic [CNT_W-1:0] react_eval [N_MODELS];
    logic [CNT_W-1:0] deact_cmt  [N_MODELS];
    logic [CNT_W-1:0] react_cmt  [N_MODELS];

    logic [IDX_W-1:0]       dom_idx;
    logic [IDX_W-1:0]       dom_q;
    logic signed [FP_W-1:0] best_mu;
    logic [N_MODELS-1:0]    mask_cmt;
    logic                   victim_found;
    int                     active_count;

    // Ready only while idle and out of reset, so a beat held during reset is never taken.
    assign mu_ready = (state == IDLE) && rst_n;
    assign accept   = mu_valid && mu_ready;

    // State register for the three-step evaluation sequence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a single pass through EVAL and COMMIT per accepted beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EVAL;
            EVAL:    state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the beat and its side-band controls at the accepting edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            mu_q       <= mu;
            thr_q      <= mu_deact_thr;
            maneuver_q <= maneuver_detected;
            enable_q   <= vs_imm_enable;
        end
    end

    // Signed argmax of the captured probabilities; strict compare keeps the lowest index on ties.
    always_comb begin
        dom_idx = '0;
        best_mu = mu_q[0];
        for (int m = 1; m < N_MODELS; m++) begin
            if (mu_q[m] > best_mu) begin
                best_mu = mu_q[m];
                dom_idx = IDX_W'(m);
            end
        end
    end

    // Hysteresis counter update: active models count low updates, inactive models count time off.
    always_comb begin
        deact_eval = deact_cnt;
        react_eval = react_cnt;
        for (int m = 0; m < N_MODELS; m++) begin
            if (model_active[m]) begin
                if (mu_q[m] < thr_q) begin
                    if (deact_cnt[m] < DEACT_MAX) begin
                        deact_eval[m] = deact_cnt[m] + CNT_W'(1);
                    end
                end else begin
                    deact_eval[m] = '0;
                end
            end else if (react_cnt[m] < REACT_MAX) begin
                react_eval[m] = react_cnt[m] + CNT_W'(1);
            end
        end
    end

    // Mask decision: overrides first, then probe reactivation, then at most one floor-limited deactivation.
    always_comb begin
        mask_cmt     = model_active;
        deact_cmt    = deact_cnt;
        react_cmt    = react_cnt;
        victim_found = 1'b0;
        active_count = 0;
        if (!enable_q || maneuver_q) begin
            mask_cmt  = ALL_ON;
            deact_cmt = '{default: '0};
            react_cmt = '{default: '0};
        end else begin
            for (int m = 0; m < N_MODELS; m++) begin
                if (!model_active[m] && (react_cnt[m] == REACT_MAX)) begin
                    mask_cmt[m]  = 1'b1;
                    react_cmt[m] = '0;
                    deact_cmt[m] = '0;
                end
            end
            for (int m = 0; m < N_MODELS; m++) begin
                active_count += int'(mask_cmt[m]);
            end
            for (int m = 0; m < N_MODELS; m++) begin
                if (!victim_found && model_active[m] && (deact_cnt[m] == DEACT_MAX)
                    && (IDX_W'(m) != dom_q)) begin
                    victim_found = 1'b1;
                    if (active_count > MIN_ACTIVE) begin
                        mask_cmt[m]  = 1'b0;
                        deact_cmt[m] = '0;
                        react_cmt[m] = '0;
                    end
                end
            end
        end
    end

    // Datapath registers: counters advance in EVAL, mask and dominant model commit in COMMIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            model_active   <= ALL_ON;
            dominant_model <= '0;
            active_valid   <= 1'b0;
            mask_changed   <= 1'b0;
            dom_q          <= '0;
            deact_cnt      <= '{default: '0};
            react_cnt      <= '{default: '0};
        end else begin
            active_valid <= 1'b0;
            mask_changed <= 1'b0;
            case (state)
                EVAL: begin
                    dom_q     <= dom_idx;
                    deact_cnt <= deact_eval;
                    react_cnt <= react_eval;
                end
                COMMIT: begin
                    model_active   <= mask_cmt;
                    dominant_model <= dom_q;
                    deact_cnt      <= deact_cmt;
                    react_cnt      <= react_cmt;
                    active_valid   <= 1'b1;
                    mask_changed   <= (mask_cmt != model_active);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vs_imm_model_scheduler.sv
// Directed self-checking bench for vs_imm_model_scheduler.
module tb_vs_imm_model_scheduler;

    localparam logic [31:0] MU_HI   = 32'h0000_F333;
    localparam logic [31:0] MU_MID  = 32'h0000_0A3D;
    localparam logic [31:0] MU_LO   = 32'h0000_0148;
    localparam logic [31:0] MU_LO1  = 32'h0000_0106;

    logic              clk;
    logic              rst_n;
    logic signed [31:0] mu [3];
    logic              mu_valid;
    logic              mu_ready;
    logic              maneuver_detected;
    logic              vs_imm_enable;
    logic signed [31:0] mu_deact_thr;
    logic [2:0]        model_active;
    logic [1:0]        dominant_model;
    logic              active_valid;
    logic              mask_changed;

    int vectors;
    int miscompares;

    vs_imm_model_scheduler dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mu                (mu),
        .mu_valid          (mu_valid),
        .mu_ready          (mu_ready),
        .maneuver_detected (maneuver_detected),
        .vs_imm_enable     (vs_imm_enable),
        .mu_deact_thr      (mu_deact_thr),
        .model_active      (model_active),
        .dominant_model    (dominant_model),
        .active_valid      (active_valid),
        .mask_changed      (mask_changed)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence wedges somewhere unexpected.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected sequence completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one beat from a negedge, waits for acceptance and the commit pulse, checks the result.
    task automatic applyStimulus(input string tag, input logic [31:0] m0, input logic [31:0] m1,
                                 input logic [31:0] m2, input logic man, input logic en,
                                 input logic [2:0] exp_mask, input logic [1:0] exp_dom,
                                 input logic exp_chg);
        int waited;
        int lat;
        mu[0]             = m0;
        mu[1]             = m1;
        mu[2]             = m2;
        maneuver_detected = man;
        vs_imm_enable     = en;
        mu_valid          = 1'b1;
        waited            = 0;
        while (!mu_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!mu_ready) begin
            checkOutput({tag, "_ready"}, 32'(mu_ready), 32'd1);
            mu_valid = 1'b0;
            return;
        end
        @(negedge clk);
        mu_valid = 1'b0;
        lat      = 1;
        while (!active_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_lat"}, 32'(lat), 32'd3);
        checkOutput({tag, "_mask"}, 32'(model_active), 32'(exp_mask));
        checkOutput({tag, "_dom"}, 32'(dominant_model), 32'(exp_dom));
        checkOutput({tag, "_chg"}, 32'(mask_changed), 32'(exp_chg));
    endtask

    // Main directed sequence.
    initial begin
        int acc;
        int pulses;
        vectors           = 0;
        miscompares       = 0;
        rst_n             = 1'b0;
        mu_valid          = 1'b0;
        maneuver_detected = 1'b0;
        vs_imm_enable     = 1'b1;
        mu_deact_thr      = 32'h0000_028F;
        mu[0]             = '0;
        mu[1]             = '0;
        mu[2]             = '0;

        // Reset held for three cycles.
        repeat (2) @(negedge clk);
        checkOutput("rst_ready_low", 32'(mu_ready), 32'd0);
        checkOutput("rst_valid_low", 32'(active_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_mask", 32'(model_active), 32'h7);
        checkOutput("rst_ready", 32'(mu_ready), 32'd1);
        checkOutput("rst_valid", 32'(active_valid), 32'd0);
        checkOutput("rst_dom", 32'(dominant_model), 32'd0);

        // Model 2 low for eight updates is dropped on the eighth.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus($sformatf("deact_b%0d", i), MU_HI, MU_MID, MU_LO, 1'b0, 1'b1,
                          (i == 8) ? 3'b011 : 3'b111, 2'd0, (i == 8));
        end

        // Model 1 low too, but the floor of two active models protects it.
        for (int i = 1; i <= 20; i++) begin
            applyStimulus($sformatf("floor_b%0d", i), MU_HI, MU_LO1, MU_LO1, 1'b0, 1'b1,
                          3'b011, 2'd0, 1'b0);
        end

        // Maneuver restores the full mask and clears all hysteresis.
        applyStimulus("man", MU_HI, MU_LO1, MU_LO, 1'b1, 1'b1, 3'b111, 2'd0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus($sformatf("man_deact_b%0d", i), MU_HI, MU_MID, MU_LO, 1'b0, 1'b1,
                          (i == 8) ? 3'b011 : 3'b111, 2'd0, (i == 8));
        end

        // Probe reactivation after 32 inactive updates, then dropped again 8 later.
        for (int i = 1; i <= 32; i++) begin
            applyStimulus($sformatf("probe_b%0d", i), MU_HI, MU_MID, MU_LO, 1'b0, 1'b1,
                          (i == 32) ? 3'b111 : 3'b011, 2'd0, (i == 32));
        end
        for (int i = 1; i <= 8; i++) begin
            applyStimulus($sformatf("redeact_b%0d", i), MU_HI, MU_MID, MU_LO, 1'b0, 1'b1,
                          (i == 8) ? 3'b011 : 3'b111, 2'd0, (i == 8));
        end

        // Reset while the beat sits in EVAL: no commit pulse, mask back to all ones.
        mu_valid          = 1'b1;
        maneuver_detected = 1'b1;
        checkOutput("abort_ready", 32'(mu_ready), 32'd1);
        @(negedge clk);
        mu_valid          = 1'b0;
        maneuver_detected = 1'b0;
        rst_n             = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (active_valid) pulses++;
        end
        checkOutput("abort_pulses", 32'(pulses), 32'd0);
        checkOutput("abort_mask", 32'(model_active), 32'h7);
        checkOutput("abort_ready_after", 32'(mu_ready), 32'd1);

        // Everything below threshold: model 1 dominant and kept, model 0 dropped, model 2 blocked.
        for (int i = 1; i <= 9; i++) begin
            applyStimulus($sformatf("alllow_b%0d", i), 32'h0000_0100, 32'h0000_0200, 32'h0000_0050,
                          1'b0, 1'b1, (i >= 8) ? 3'b110 : 3'b111, 2'd1, (i == 8));
        end

        // Negative mu on model 0 and a tie between 1 and 2: signed argmax picks model 1.
        applyStimulus("tie_signed", 32'hFFFF_0000, 32'h0000_0100, 32'h0000_0100, 1'b0, 1'b1,
                      3'b110, 2'd1, 1'b0);

        // Disabled scheduling forces the full mask and clears model 2's saturated count.
        applyStimulus("disable", MU_HI, MU_MID, MU_LO, 1'b0, 1'b0, 3'b111, 2'd0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus($sformatf("post_dis_b%0d", i), MU_HI, MU_MID, MU_LO, 1'b0, 1'b1,
                          (i == 8) ? 3'b011 : 3'b111, 2'd0, (i == 8));
        end

        // Continuous mu_valid: one acceptance every third cycle.
        mu[0]    = 32'h0000_8000;
        mu[1]    = 32'h0000_4000;
        mu[2]    = 32'h0000_4000;
        mu_valid = 1'b1;
        acc      = 0;
        for (int i = 0; i < 15; i++) begin
            if (mu_ready) acc++;
            @(negedge clk);
        end
        mu_valid = 1'b0;
        checkOutput("stream_accepts", 32'(acc), 32'd5);
        repeat (4) @(negedge clk);
        checkOutput("stream_mask", 32'(model_active), 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
